read_rw: RTL
============

READ_RW -- requirements
Module: read_rw

Interface
REQ-001 The block SHALL have parameter PEND_DEPTH, default 4, giving the maximum number of outstanding data-array reads; legal values are powers of two from 2 to 16.
REQ-002 The block SHALL have these ports:
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- task_in_valid  in  1  input task offered
- task_in_ready  out  1  input task accepted
- task_in  in  rw_read_t  task_desc, cq_slot, thread
- arvalid  out  1  data-array read request
- arready  in  1  read request accepted
- araddr  out  32  word address, tags bypassed
- rvalid  in  1  read response; in order; no backpressure
- rdata  in  512  response line
- task_out_valid  out  1  completed task offered
- task_out_ready  in  1  downstream accepts
- task_out  out  rw_write_t  task_desc, cq_slot, thread, object
- task_out_fifo_occ  in  fifo_size_t  downstream FIFO occupancy
- reg_bus  —  reg_bus_t  configuration and status bus

Function
REQ-003 The request address SHALL be araddr = base_rw_addr + (task_in.task_desc.locale << 2), computed modulo 2^32.
REQ-004 Issue SHALL be allowed when task_in_valid=1, pend_cnt < PEND_DEPTH, and task_out_fifo_occ < almost_full_thresh; arvalid SHALL equal that condition.
REQ-005 task_in_ready SHALL equal arvalid & arready; an accepted task SHALL be written into the pending queue at alloc_ptr in the same cycle.
REQ-006 The pending queue SHALL be a PEND_DEPTH-entry circular buffer with three pointers:
- alloc_ptr: advances on issue
- fill_ptr: advances on rvalid
- head_ptr: advances on task_out_valid & task_out_ready
- all three SHALL wrap modulo PEND_DEPTH.
REQ-007 On rvalid, the entry at fill_ptr SHALL store object = rdata[locale[3:0]*32 +: 32] and SHALL set its filled flag.
REQ-008 rvalid arriving while no entry is allocated and unfilled SHALL be ignored and SHALL set the sticky flag err_spurious.
REQ-009 task_out_valid SHALL be 1 exactly when the head entry is filled; task_out SHALL present that entry's fields; task_out SHALL hold stable while task_out_valid=1 and task_out_ready=0.
REQ-010 pend_cnt (0..PEND_DEPTH) SHALL increment on issue and decrement on dequeue; on the same cycle both SHALL cancel, so a full queue SHALL accept a new issue in the same cycle its head is dequeued.
REQ-011 Fill and dequeue of the same entry SHALL NOT occur in the same cycle; minimum latency from rvalid to task_out_valid SHALL be 1 cycle.
REQ-012 Completed-read counter read_cnt (32 bits) SHALL increment on each dequeue and SHALL wrap at 2^32.
REQ-013 Register writes (reg_bus.wvalid):
- RW_BASE_ADDR: base_rw_addr <= {wdata[29:0], 2'b00}
- CORE_FIFO_OUT_ALMOST_FULL_THRESHOLD: almost_full_thresh <= wdata
- other addresses: ignored.
REQ-014 Register reads: reg_bus.rvalid SHALL be reg_bus.arvalid delayed by 1 cycle; rdata SHALL be read_cnt when araddr = RW_READ_COUNT, {31'b0, err_spurious} when araddr = RW_READ_STATUS, otherwise 0.

Reset
REQ-015 While rstn=0 the block SHALL hold:
- arvalid=0, task_in_ready=0, task_out_valid=0, reg_bus.rvalid=0
- all pointers and pend_cnt = 0, all filled flags cleared
- read_cnt=0, err_spurious=0, base_rw_addr=0, almost_full_thresh=all ones.
REQ-016 A reset during outstanding reads SHALL discard all pending entries; the integrator SHALL reset the data array with this block so that no stale responses are delivered.

Structure
REQ-017 rw_read_t, the RW_READ_COUNT and RW_READ_STATUS addresses, and PEND_DEPTH's default value SHALL reside in package swarm; rw_write_t, ro1_in_t, RW_BASE_ADDR, and fifo_size_t SHALL be reused from that package.
REQ-018 The pending queue SHALL be implemented as sub-module rw_pend_queue, with separate alloc, fill, and dequeue ports; all other logic SHALL reside in read_rw.

Verification
REQ-019 Basic read: base=0x1000, locale=0x13, word 3 of rdata = 0xDEADBEEF, response 2 cycles after issue -> araddr=0x104C; task_out.object=0xDEADBEEF one cycle after rvalid.
REQ-020 Queue full: arready=1, responses withheld, 6 tasks offered, PEND_DEPTH=4 -> exactly 4 issues; arvalid=0 until the first dequeue; dequeue and issue occur in the same cycle.
REQ-021 Ordering under backpressure: 4 responses, then task_out_ready=0 for 5 cycles -> task_out stable; 4 outputs emitted in issue order with the correct objects.
REQ-022 Threshold stall: thresh=3, occ=3 -> arvalid=0 and task_in_ready=0; occ drops to 2 -> issue in that same cycle.
REQ-023 Spurious response: rvalid with an empty queue -> no output; RW_READ_STATUS reads 1.
REQ-024 Reset mid-flight: 3 outstanding reads, rstn=0 for 1 cycle -> all outputs at reset values; RW_READ_COUNT reads 0; a subsequent read completes normally.

Source files
------------

// File: rtl/swarm_pkg.sv
// Shared types, register addresses and defaults for the swarm task pipeline.
package swarm;

    localparam int unsigned RW_PEND_DEPTH = 4;

    localparam logic [15:0] RW_BASE_ADDR                        = 16'h0010;
    localparam logic [15:0] CORE_FIFO_OUT_ALMOST_FULL_THRESHOLD = 16'h0014;
    localparam logic [15:0] RW_READ_COUNT                       = 16'h0020;
    localparam logic [15:0] RW_READ_STATUS                      = 16'h0024;

    typedef logic [7:0]  fifo_size_t;
    typedef logic [31:0] ts_t;
    typedef logic [31:0] locale_t;
    typedef logic [31:0] object_t;
    typedef logic [3:0]  ttype_t;
    typedef logic [5:0]  cq_slice_slot_t;
    typedef logic [3:0]  thread_id_t;

    typedef struct packed {
        ts_t         ts;
        locale_t     locale;
        ttype_t      ttype;
        logic [63:0] args;
    } task_t;

    typedef struct packed {
        task_t          task_desc;
        cq_slice_slot_t cq_slot;
        thread_id_t     thread;
    } ro1_in_t;

    typedef struct packed {
        task_t          task_desc;
        cq_slice_slot_t cq_slot;
        thread_id_t     thread;
    } rw_read_t;

    typedef struct packed {
        task_t          task_desc;
        cq_slice_slot_t cq_slot;
        thread_id_t     thread;
        object_t        object;
    } rw_write_t;

endpackage

// File: rtl/reg_bus_t.sv
// Simple configuration/status register bus: write channel plus a
// one-cycle-latency read channel.
interface reg_bus_t;
    logic        wvalid;
    logic [15:0] waddr;
    logic [31:0] wdata;
    logic        arvalid;
    logic [15:0] araddr;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output wvalid, waddr, wdata, arvalid, araddr,
                    input  rvalid, rdata);
    modport slave  (input  wvalid, waddr, wdata, arvalid, araddr,
                    output rvalid, rdata);
endinterface

// File: rtl/rw_pend_queue.sv
// Circular buffer of in-flight read tasks: allocated on issue, filled in
// order by read responses, dequeued in order once filled.
module rw_pend_queue
    import swarm::*;
#(
    parameter int unsigned PEND_DEPTH = RW_PEND_DEPTH
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       alloc_en,
    input  rw_read_t   alloc_task,
    input  logic       fill_en,
    input  object_t    fill_obj,
    output logic       fill_ready,
    output logic [3:0] fill_word,
    input  logic       deq_en,
    output logic       head_valid,
    output rw_write_t  head_task
);

    localparam int unsigned PW = $clog2(PEND_DEPTH);

    rw_read_t              mem [PEND_DEPTH];
    object_t               obj [PEND_DEPTH];
    logic [PW-1:0]         alloc_ptr, fill_ptr, head_ptr;
    logic [PEND_DEPTH-1:0] valid_q, filled_q, valid_d, filled_d;

    // Flag update; a dequeue frees a slot before an allocation may reuse it
    // in the same cycle, and a fresh allocation always starts unfilled.
    always_comb begin
        valid_d  = valid_q;
        filled_d = filled_q;
        if (deq_en) begin
            valid_d[head_ptr]  = 1'b0;
            filled_d[head_ptr] = 1'b0;
        end
        if (fill_en)
            filled_d[fill_ptr] = 1'b1;
        if (alloc_en) begin
            valid_d[alloc_ptr]  = 1'b1;
            filled_d[alloc_ptr] = 1'b0;
        end
    end

    // Pointers and flags, cleared by reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            head_ptr  <= '0;
            valid_q   <= '0;
            filled_q  <= '0;
        end else begin
            valid_q  <= valid_d;
            filled_q <= filled_d;
            if (alloc_en) alloc_ptr <= alloc_ptr + 1'b1;
            if (fill_en)  fill_ptr  <= fill_ptr + 1'b1;
            if (deq_en)   head_ptr  <= head_ptr + 1'b1;
        end
    end

    // Entry payload storage; no reset needed, guarded by the flags.
    always_ff @(posedge clk) begin
        if (alloc_en) mem[alloc_ptr] <= alloc_task;
        if (fill_en)  obj[fill_ptr]  <= fill_obj;
    end

    // Fill-side and head-side views of the buffer.
    always_comb begin
        fill_ready          = valid_q[fill_ptr] & ~filled_q[fill_ptr];
        fill_word           = mem[fill_ptr].task_desc.locale[3:0];
        head_valid          = valid_q[head_ptr] & filled_q[head_ptr];
        head_task.task_desc = mem[head_ptr].task_desc;
        head_task.cq_slot   = mem[head_ptr].cq_slot;
        head_task.thread    = mem[head_ptr].thread;
        head_task.object    = obj[head_ptr];
    end

endmodule

// File: rtl/read_rw.sv
// Read stage for read-write tasks: issues a data-array read per task,
// matches in-order responses to pending tasks and emits task plus object.
module read_rw
    import swarm::*;
#(
    parameter int unsigned PEND_DEPTH = RW_PEND_DEPTH
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           task_in_valid,
    output logic           task_in_ready,
    input  rw_read_t       task_in,
    output logic           arvalid,
    input  logic           arready,
    output logic [31:0]    araddr,
    input  logic           rvalid,
    input  logic [511:0]   rdata,
    output logic           task_out_valid,
    input  logic           task_out_ready,
    output rw_write_t      task_out,
    input  fifo_size_t     task_out_fifo_occ,
    reg_bus_t.slave        reg_bus
);

    localparam int unsigned      CW      = $clog2(PEND_DEPTH + 1);
    localparam logic [CW-1:0]    CNT_MAX = CW'(PEND_DEPTH);

    logic [CW-1:0] pend_cnt;
    logic [31:0]   base_rw_addr;
    logic [31:0]   read_cnt;
    fifo_size_t    almost_full_thresh;
    logic          err_spurious;

    logic          head_valid, fill_ready, fill_en, spurious, issue, deq;
    logic [3:0]    fill_word;
    object_t       fill_obj;
    logic          unused_wdata;

    assign unused_wdata = ^reg_bus.wdata[31:30];

    // Issue/dequeue handshakes; a dequeue frees room for an issue in the same cycle.
    always_comb begin
        task_out_valid = head_valid & rstn;
        deq            = task_out_valid & task_out_ready;
        arvalid        = rstn & task_in_valid
                       & ((pend_cnt < CNT_MAX) | deq)
                       & (task_out_fifo_occ < almost_full_thresh);
        task_in_ready  = arvalid & arready;
        issue          = task_in_ready;
        araddr         = base_rw_addr + {task_in.task_desc.locale[29:0], 2'b00};
        fill_en        = rvalid & fill_ready;
        spurious       = rvalid & ~fill_ready;
        fill_obj       = rdata[{fill_word, 5'd0} +: 32];
    end

    rw_pend_queue #(
        .PEND_DEPTH (PEND_DEPTH)
    ) u_pend (
        .clk        (clk),
        .rstn       (rstn),
        .alloc_en   (issue),
        .alloc_task (task_in),
        .fill_en    (fill_en),
        .fill_obj   (fill_obj),
        .fill_ready (fill_ready),
        .fill_word  (fill_word),
        .deq_en     (deq),
        .head_valid (head_valid),
        .head_task  (task_out)
    );

    // Occupancy, counters, configuration and register read-back.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            pend_cnt           <= '0;
            read_cnt           <= '0;
            err_spurious       <= 1'b0;
            base_rw_addr       <= '0;
            almost_full_thresh <= '1;
            reg_bus.rvalid     <= 1'b0;
            reg_bus.rdata      <= '0;
        end else begin
            case ({issue, deq})
                2'b10:   pend_cnt <= pend_cnt + 1'b1;
                2'b01:   pend_cnt <= pend_cnt - 1'b1;
                default: pend_cnt <= pend_cnt;
            endcase
            if (deq)      read_cnt     <= read_cnt + 32'd1;
            if (spurious) err_spurious <= 1'b1;
            if (reg_bus.wvalid) begin
                if (reg_bus.waddr == RW_BASE_ADDR)
                    base_rw_addr <= {reg_bus.wdata[29:0], 2'b00};
                else if (reg_bus.waddr == CORE_FIFO_OUT_ALMOST_FULL_THRESHOLD)
                    almost_full_thresh <= reg_bus.wdata[$bits(fifo_size_t)-1:0];
            end
            reg_bus.rvalid <= reg_bus.arvalid;
            if (reg_bus.araddr == RW_READ_COUNT)
                reg_bus.rdata <= read_cnt;
            else if (reg_bus.araddr == RW_READ_STATUS)
                reg_bus.rdata <= {31'b0, err_spurious};
            else
                reg_bus.rdata <= '0;
        end
    end

endmodule
